// File: rtl/core_mem_dmem_responder_pkg.sv
// rtl/core_mem_dmem_responder_pkg.sv - shared widths and FSM encoding for the dmem responder
//
// Purpose: bus widths shared between the core and the dmem responder, plus the
//          responder FSM state encoding.
// Ports:   none (package).
package core_mem_dmem_responder_pkg;

  localparam int MEM_ADDR_R = 64;
  localparam int MEM_DATA_R = 64;
  localparam int MEM_STRB_R = 8;

  typedef enum logic [1:0] {
    DMEM_RSP_IDLE = 2'd0,
    DMEM_RSP_WAIT = 2'd1,
    DMEM_RSP_RESP = 2'd2
  } dmem_rsp_state_e;

endpackage

// File: rtl/core_mem_sram.sv
// rtl/core_mem_sram.sv - synchronous single-port byte-strobed 64-bit SRAM
//
// Purpose: one access per cycle; a write updates only the strobed byte lanes,
//          a read registers the whole word onto rdata. Contents are not reset.
// Ports:   clk   - clock
//          en    - access enable
//          wen   - 1 = write, 0 = read (when en)
//          strb  - byte lane strobes for writes
//          idx   - word index
//          wdata - write data
//          rdata - registered read data (holds between reads)
module core_mem_sram
  import core_mem_dmem_responder_pkg::*;
#(
  parameter int DEPTH = 8192,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  wen,
  input  logic [MEM_STRB_R-1:0] strb,
  input  logic [IW-1:0]         idx,
  input  logic [MEM_DATA_R-1:0] wdata,
  output logic [MEM_DATA_R-1:0] rdata
);

  logic [MEM_DATA_R-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (wen) begin
        for (int i = 0; i < MEM_STRB_R; i++) begin
          if (strb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/core_mem_dmem_responder.sv
// rtl/core_mem_dmem_responder.sv - dmem bus target with programmable latency
//
// Purpose: accepts one dmem request at a time, holds it for LATENCY cycles,
//          then answers with a one-cycle grant carrying read data or error.
//          Optional random stall: define CORE_MEM_DMEM_RAND_STALL_EN to add
//          0..3 LFSR-chosen extra wait cycles per request.
// Ports:   g_clk      - clock
//          g_reset    - synchronous active-high reset
//          dmem_req   - request valid, held until grant
//          dmem_addr  - byte address
//          dmem_wen   - 1 = write, 0 = read
//          dmem_strb  - byte lane strobes
//          dmem_wdata - write data
//          dmem_gnt   - one-cycle response valid
//          dmem_err   - response error (with dmem_gnt)
//          dmem_rdata - read data (with dmem_gnt)
module core_mem_dmem_responder
  import core_mem_dmem_responder_pkg::*;
#(
  parameter logic [63:0] MEM_BASE = 64'h0000_0000_8000_0000,
  parameter int          MEM_SIZE = 65536,
  parameter int          LATENCY  = 1
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic                  dmem_req,
  input  logic [MEM_ADDR_R-1:0] dmem_addr,
  input  logic                  dmem_wen,
  input  logic [MEM_STRB_R-1:0] dmem_strb,
  input  logic [MEM_DATA_R-1:0] dmem_wdata,
  output logic                  dmem_gnt,
  output logic                  dmem_err,
  output logic [MEM_DATA_R-1:0] dmem_rdata
);

  localparam int DEPTH = MEM_SIZE / 8;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dmem_rsp_state_e       state;
  logic [31:0]           cnt;
  logic [MEM_ADDR_R-1:0] addr_q;
  logic [MEM_DATA_R-1:0] wdata_q;
  logic [MEM_STRB_R-1:0] strb_q;
  logic                  wen_q;
  logic [31:0]           stall;

  logic                  lat_ok;
  logic [IW-1:0]         lat_idx;
  logic [IW-1:0]         req_idx;
  logic                  fire;
  logic                  sram_en;
  logic                  sram_wen;
  logic [IW-1:0]         sram_idx;
  logic [MEM_DATA_R-1:0] sram_rdata;

  // Subtraction only happens after the lower bound holds, so no wrap at 2^64.
  function automatic logic in_range(input logic [MEM_ADDR_R-1:0] a);
    return (a >= MEM_BASE) && ((a - MEM_BASE) < 64'(MEM_SIZE));
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [MEM_ADDR_R-1:0] a);
    return IW'((a - MEM_BASE) >> 3);
  endfunction

  assign lat_ok  = in_range(addr_q);
  assign lat_idx = word_idx(addr_q);
  assign req_idx = word_idx(dmem_addr);
  assign fire    = (state == DMEM_RSP_WAIT) && dmem_req && (cnt == '0);

  // The single SRAM port reads at acceptance (data then sits on sram_rdata
  // through WAIT, since nothing else touches the array) and writes on the
  // WAIT->RESP edge using the latched request.
  assign sram_en  = !g_reset && (((state == DMEM_RSP_IDLE) && dmem_req) ||
                                 (fire && wen_q && lat_ok));
  assign sram_wen = (state == DMEM_RSP_WAIT);
  assign sram_idx = (state == DMEM_RSP_IDLE) ? req_idx : lat_idx;

  core_mem_sram #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_sram (
    .clk   (g_clk),
    .en    (sram_en),
    .wen   (sram_wen),
    .strb  (strb_q),
    .idx   (sram_idx),
    .wdata (wdata_q),
    .rdata (sram_rdata)
  );

`ifdef CORE_MEM_DMEM_RAND_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge g_clk) begin
    if (g_reset) lfsr <= 16'hACE1;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = {30'd0, lfsr[1:0]};
`else
  assign stall = '0;
`endif

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state      <= DMEM_RSP_IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      wen_q      <= 1'b0;
      dmem_gnt   <= 1'b0;
      dmem_err   <= 1'b0;
      dmem_rdata <= '0;
    end else begin
      dmem_gnt   <= 1'b0;
      dmem_err   <= 1'b0;
      dmem_rdata <= '0;
      case (state)
        DMEM_RSP_IDLE: begin
          if (dmem_req) begin
            addr_q  <= dmem_addr;
            wdata_q <= dmem_wdata;
            strb_q  <= dmem_strb;
            wen_q   <= dmem_wen;
            cnt     <= 32'(LATENCY - 1) + stall;
            state   <= DMEM_RSP_WAIT;
          end
        end
        DMEM_RSP_WAIT: begin
          if (!dmem_req) begin
            state <= DMEM_RSP_IDLE;
          end else if (cnt == '0) begin
            state      <= DMEM_RSP_RESP;
            dmem_gnt   <= 1'b1;
            dmem_err   <= !lat_ok;
            dmem_rdata <= (lat_ok && !wen_q) ? sram_rdata : '0;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        DMEM_RSP_RESP: state <= DMEM_RSP_IDLE;
        default:       state <= DMEM_RSP_IDLE;
      endcase
    end
  end

endmodule
